prog_assembler: RTL and testbench

Parametrised, sequential successor to the combinational instruction assembler. It turns front-panel op-request strobes plus value/dest/src fields into 32-bit VDP instruction words. Each word is written, one per request, into a program memory through a write port with an auto-incrementing address. It sits between the programming panel and the instruction RAM, and provides edge detection, a fill counter, full/overflow status and a soft clear.

---
 rtl/prog_assembler.sv | 123 ++++++++++++
 tb/tb_prog_assembler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/prog_assembler.sv
// Front-panel instruction assembler: edge-detected op requests become 32-bit VDP words
// written sequentially into program memory. Optional ASM_PARITY_EN adds even parity in bit 31.
module prog_assembler #(
    parameter int OP_COUNT = 8,
    parameter int ADDR_W   = 4,
    parameter int REG_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                clear,
    input  logic [15:0]         value,
    input  logic [REG_W-1:0]    dest,
    input  logic [REG_W-1:0]    src,
    input  logic [OP_COUNT-1:0] op_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_data,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                overflow,
    output logic                busy
);

    // state | meaning
    // IDLE  | waiting for a request edge in programming mode
    // WRITE | mem_we high for one cycle at wr_ptr
    // HOLD  | waiting for all request lines to be released
    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

    state_t              state, state_nx;
    logic [OP_COUNT-1:0] req_q;
    logic [OP_COUNT-1:0] rise;
    logic [2:0]          opcode;
    logic [31:0]         inst;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W:0]     cnt;
    logic                ovf;
    logic                accept;
    logic                reject;

    assign rise = op_req & ~req_q;

    // Highest simultaneous edge wins; lower ones are dropped.
    always_comb begin
        opcode = '0;
        for (int i = 0; i < OP_COUNT; i++) begin
            if (rise[i]) opcode = 3'(i);
        end
    end

    always_comb begin
        inst               = '0;
        inst[15:0]         = value;
        inst[16 +: REG_W]  = dest;
        inst[20 +: REG_W]  = src;
        inst[26:24]        = opcode;
`ifdef ASM_PARITY_EN
        inst[31]           = ^inst[30:0];
`else
        inst[31]           = 1'b0;
`endif
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        case (state)
            IDLE: begin
                if (mode && |rise) begin
                    if (!full) begin
                        accept   = 1'b1;
                        state_nx = WRITE;
                    end else begin
                        reject   = 1'b1;
                    end
                end
            end
            WRITE:   state_nx = HOLD;
            HOLD:    if (op_req == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_q    <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            mem_data <= '0;
        end else begin
            req_q <= op_req;
            state <= state_nx;
            if (clear) begin
                wr_ptr <= '0;
                cnt    <= '0;
                ovf    <= 1'b0;
            end else begin
                if (accept) mem_data <= inst;
                if (reject) ovf <= 1'b1;
                if (state == WRITE) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    cnt    <= cnt + (ADDR_W+1)'(1);
                end
            end
        end
    end

    // Strobe is killed in the same cycle a clear or reset is presented.
    assign mem_we   = (state == WRITE) && !clear && !rst;
    assign mem_addr = wr_ptr;
    assign count    = cnt;
    assign full     = (cnt == DEPTH);
    assign overflow = ovf;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_prog_assembler.sv
// Scoreboard bench for prog_assembler (ADDR_W=2): expected writes are queued by the
// stimulus and checked by a negedge monitor whenever mem_we is seen.
module tb_prog_assembler;

    localparam int OP_COUNT = 8;
    localparam int ADDR_W   = 2;
    localparam int REG_W    = 2;

    logic                clk = 1'b0;
    logic                rst, mode, clear;
    logic [15:0]         value;
    logic [REG_W-1:0]    dest, src;
    logic [OP_COUNT-1:0] op_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_data;
    logic [ADDR_W:0]     count;
    logic                full, overflow, busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;
    wr_t exp_q[$];

    prog_assembler #(.OP_COUNT(OP_COUNT), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .clear(clear),
        .value(value), .dest(dest), .src(src), .op_req(op_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .count(count), .full(full), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] par(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef ASM_PARITY_EN
        r[31] = ^w[30:0];
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every observed write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h expected no write", mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_data !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                             mem_addr, mem_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise op lines for one edge, release, and let the FSM return to IDLE.
    task automatic pulse(input logic [7:0] ops, input logic [15:0] v, input logic [1:0] d,
                         input logic [1:0] s, input logic exp_wr, input logic [ADDR_W-1:0] a,
                         input logic [31:0] w);
        value = v; dest = d; src = s;
        if (exp_wr) exp_q.push_back('{addr: a, data: par(w)});
        op_req = ops;
        tick();
        op_req = '0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; clear = 1'b0;
        value = '0; dest = '0; src = '0; op_req = '0;
        tick(); tick();
        @(negedge clk);
        check("rst_mem_we",   32'(mem_we),   0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_data", mem_data,      0);
        check("rst_count",    32'(count),    0);
        check("rst_full",     32'(full),     0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_busy",     32'(busy),     0);
        tick();
        rst = 1'b0; mode = 1'b1;
        tick();

        pulse(8'h01, 16'h1234, 2'd2, 2'd1, 1'b1, 2'd0, 32'h00121234);
        check("count_1", 32'(count), 1);

        // Simultaneous op0/op7 edges, then a long hold: exactly one write.
        value = 16'h00FF; dest = 2'd3; src = 2'd0;
        exp_q.push_back('{addr: 2'd1, data: par(32'h070300FF)});
        op_req = 8'h81;
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("busy_hold", 32'(busy), 1);
        op_req = '0;
        tick(); tick();
        check("count_2", 32'(count), 2);
        check("busy_idle", 32'(busy), 0);

        pulse(8'h08, 16'hBEEF, 2'd1, 2'd2, 1'b1, 2'd2, 32'h0321BEEF);
        pulse(8'h24, 16'h0007, 2'd0, 2'd3, 1'b1, 2'd3, 32'h05300007);
        check("count_4", 32'(count), 4);
        check("full_set", 32'(full), 1);
        check("addr_wrap", 32'(mem_addr), 0);
        check("ovf_before", 32'(overflow), 0);

        // Request while full is rejected and flagged.
        value = 16'h5555; op_req = 8'h02;
        tick();
        check("busy_reject", 32'(busy), 0);
        op_req = '0;
        tick(); tick();
        check("overflow_set", 32'(overflow), 1);
        check("count_full", 32'(count), 4);

        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_count", 32'(count), 0);
        check("clr_full", 32'(full), 0);
        check("clr_overflow", 32'(overflow), 0);

        pulse(8'h04, 16'hA5A5, 2'd3, 2'd3, 1'b1, 2'd0, 32'h0233A5A5);
        check("count_after_clr", 32'(count), 1);

        // Programming mode gates edges in IDLE.
        mode = 1'b0;
        op_req = 8'h01; tick();
        check("mode0_busy", 32'(busy), 0);
        op_req = '0; tick();
        op_req = 8'h01; tick();
        mode = 1'b1; tick(); tick();
        check("mode_raise_busy", 32'(busy), 0);
        check("mode_count", 32'(count), 1);
        op_req = '0; tick();
        pulse(8'h01, 16'h0001, 2'd0, 2'd0, 1'b1, 2'd1, 32'h00000001);
        check("count_mode", 32'(count), 2);

        // Clear during WRITE aborts the write.
        value = 16'h3333; op_req = 8'h10;
        tick();
        clear = 1'b1; op_req = '0;
        @(negedge clk);
        check("clr_write_we", 32'(mem_we), 0);
        tick();
        clear = 1'b0;
        check("clr_write_count", 32'(count), 0);
        check("clr_write_busy", 32'(busy), 0);

        // Reset during WRITE behaves the same.
        pulse(8'h01, 16'h0042, 2'd1, 2'd0, 1'b1, 2'd0, 32'h00010042);
        value = 16'h7777; op_req = 8'h40;
        tick();
        rst = 1'b1; op_req = '0;
        @(negedge clk);
        check("rst_write_we", 32'(mem_we), 0);
        tick();
        rst = 1'b0;
        check("rst_write_count", 32'(count), 0);
        check("rst_write_busy", 32'(busy), 0);
        check("rst_write_data", mem_data, 0);
        tick();

        pulse(8'h40, 16'hABCD, 2'd1, 2'd3, 1'b1, 2'd0, 32'h0631ABCD);
        check("count_final", 32'(count), 1);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
